// File: rtl/bcd_display_ctrl_pkg.sv
// ============================================================================
// Module  : bcd_display_ctrl_pkg
// Brief   : Shared types and constants for the BCD display controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_display_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle   = 2'd0;
  localparam state_t c_st_conv   = 2'd1;
  localparam state_t c_st_commit = 2'd2;

  localparam int c_num_digits       = 4;
  localparam int c_scan_div_default = 50000;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_0     = 7'b1000000;
  localparam logic [6:0] c_seg_1     = 7'b1111001;
  localparam logic [6:0] c_seg_2     = 7'b0100100;
  localparam logic [6:0] c_seg_3     = 7'b0110000;
  localparam logic [6:0] c_seg_4     = 7'b0011001;
  localparam logic [6:0] c_seg_5     = 7'b0010010;
  localparam logic [6:0] c_seg_6     = 7'b0000010;
  localparam logic [6:0] c_seg_7     = 7'b1111000;
  localparam logic [6:0] c_seg_8     = 7'b0000000;
  localparam logic [6:0] c_seg_9     = 7'b0010000;
  localparam logic [6:0] c_seg_blank = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/bcd_display_ctrl_seg7_encode.sv
// ============================================================================
// Module  : seg7_encode
// Brief   : Combinational BCD digit to active-low 7-segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_encode
  import bcd_display_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = c_seg_blank;
    if (!blank) begin
      case (digit)
        4'd0:    seg = c_seg_0;
        4'd1:    seg = c_seg_1;
        4'd2:    seg = c_seg_2;
        4'd3:    seg = c_seg_3;
        4'd4:    seg = c_seg_4;
        4'd5:    seg = c_seg_5;
        4'd6:    seg = c_seg_6;
        4'd7:    seg = c_seg_7;
        4'd8:    seg = c_seg_8;
        4'd9:    seg = c_seg_9;
        default: seg = c_seg_blank;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_ctrl.sv
// ============================================================================
// Module  : bcd_display_ctrl
// Brief   : 8-bit binary to BCD converter with multiplexed 4-digit display.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_ctrl
  import bcd_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = c_scan_div_default,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int c_pre_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_idx_w = $clog2(c_num_digits);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);

  state_t               r_state;
  logic [2:0]           r_iter;
  logic [7:0]           r_sr;
  logic [11:0]          r_scr;
  logic [11:0]          r_bcd;
  logic                 r_done;
  logic [c_pre_w-1:0]   r_pre;
  logic [c_idx_w-1:0]   r_idx;

  logic [11:0]          w_adj;
  logic [19:0]          w_shift;
  logic [15:0]          w_digits;
  logic [3:0]           w_digit;
  logic [3:0]           w_lz;
  logic                 w_blank;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
      assign w_adj[4*gi +: 4] = (r_scr[4*gi +: 4] >= 4'd5) ? r_scr[4*gi +: 4] + 4'd3
                                                            : r_scr[4*gi +: 4];
    end
  endgenerate

  assign w_shift = {w_adj, r_sr} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_iter  <= '0;
      r_sr    <= '0;
      r_scr   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (load) begin
            r_state <= c_st_conv;
            r_sr    <= data;
            r_scr   <= '0;
            r_iter  <= '0;
          end
        end
        c_st_conv: begin
          r_scr  <= w_shift[19:8];
          r_sr   <= w_shift[7:0];
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= c_st_commit;
        end
        c_st_commit: begin
          r_bcd   <= r_scr;
          r_done  <= 1'b1;
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Free-running scan, deliberately decoupled from the converter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == c_pre_last) begin
      r_pre <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_digits = {4'h0, r_bcd};
  assign w_digit  = w_digits[{r_idx, 2'b00} +: 4];

  // w_lz[i]: digit i and everything above it are zero; ones is never blanked
  assign w_lz[3] = (w_digits[15:12] == 4'd0);
  assign w_lz[2] = w_lz[3] & (w_digits[11:8] == 4'd0);
  assign w_lz[1] = w_lz[2] & (w_digits[7:4] == 4'd0);
  assign w_lz[0] = 1'b0;

  assign w_blank = BLANK_LZ & w_lz[r_idx];
  assign an      = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);

  seg7_encode u_seg7 (
    .digit (w_digit),
    .blank (w_blank),
    .seg   (seg)
  );

  assign busy = (r_state != c_st_idle);
  assign done = r_done;
  assign bcd  = {4'h0, r_bcd};

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_ctrl.sv
// ============================================================================
// Module  : tb_bcd_display_ctrl
// Brief   : Self-checking bench for bcd_display_ctrl (two blanking variants).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_ctrl;

  localparam int c_sd = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  data;

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] bcd_a, bcd_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc;
  logic [15:0] model_bcd;

  logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct {
    logic [7:0]  d;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [10];

  bcd_display_ctrl #(.SCAN_DIV(c_sd), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .data(data), .load(load),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .an(an_a), .seg(seg_a)
  );

  bcd_display_ctrl #(.SCAN_DIV(c_sd), .BLANK_LZ(1'b0)) u_dut_nolz (
    .clk(clk), .rst(rst), .data(data), .load(load),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .an(an_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the scan slot follows from this directly
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [10:0] exp_disp(input logic [15:0] b, input int idx, input bit blz);
    logic [3:0] d;
    bit         blank;
    d     = b[idx*4 +: 4];
    blank = blz && (idx != 0) && ((b >> (4 * idx)) == 16'd0);
    if (blank) return {4'b1111, 7'b1111111};
    return {~(4'b0001 << idx), pat[d]};
  endfunction

  task automatic check_disp(input logic [15:0] b);
    int idx;
    idx = (cyc / c_sd) % 4;
    check("disp_lz",   {21'd0, an_a, seg_a}, {21'd0, exp_disp(b, idx, 1'b1)});
    check("disp_nolz", {21'd0, an_b, seg_b}, {21'd0, exp_disp(b, idx, 1'b0)});
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic convert(input logic [7:0] d, input logic [15:0] expb);
    logic [15:0] prev;
    int busy_n, done_n, done_t;
    bit hold_ok;
    prev = model_bcd; busy_n = 0; done_n = 0; done_t = -1; hold_ok = 1'b1;
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int t = 0; t < 15; t++) begin
      if (t > 0) @(negedge clk);
      busy_n += int'(busy_a);
      if (done_a) begin done_n++; done_t = t; end
      if (t < 9 && bcd_a !== prev) hold_ok = 1'b0;
      check_disp((t >= 9) ? expb : prev);
    end
    model_bcd = expb;
    check("busy_cycles",  busy_n, 9);
    check("done_count",   done_n, 1);
    check("done_latency", done_t, 9);
    check("bcd",          bcd_a, expb);
    check("bcd_nolz",     bcd_b, expb);
    check("bcd_hold",     {31'd0, hold_ok}, 1);
  endtask

  initial begin
    int n, last_t, dv;
    tbl[0] = '{8'd255, 16'h0255};
    tbl[1] = '{8'd0,   16'h0000};
    tbl[2] = '{8'd100, 16'h0100};
    tbl[3] = '{8'd42,  16'h0042};
    tbl[4] = '{8'd9,   16'h0009};
    tbl[5] = '{8'd10,  16'h0010};
    tbl[6] = '{8'd99,  16'h0099};
    tbl[7] = '{8'd199, 16'h0199};
    tbl[8] = '{8'd5,   16'h0005};
    tbl[9] = '{8'd250, 16'h0250};

    rst = 1'b1; load = 1'b0; data = 8'd0; model_bcd = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 0);
    check("rst_done", {31'd0, done_a}, 0);
    check("rst_bcd",  bcd_a, 16'h0000);
    check("rst_an",   an_a, 4'b1110);
    check("rst_seg",  seg_a, 7'b1000000);
    check("rst_an_nolz", an_b, 4'b1110);

    // First load lands on the very first edge after release
    rst = 1'b0;
    convert(8'd255, 16'h0255);

    for (int i = 0; i < 10; i++) convert(tbl[i].d, tbl[i].exp);

    for (int i = 0; i < 25; i++) begin
      dv = int'($urandom_range(0, 255));
      convert(8'(dv), to_bcd(dv));
    end

    // Loads and data changes while busy are ignored
    n = 0;
    data = 8'd123; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int t = 0; t < 26; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 3) begin data = 8'd77; load = 1'b1; end
      if (t == 5) load = 1'b0;
      if (done_a) n++;
    end
    check("drop_done_count", n, 1);
    check("drop_bcd", bcd_a, 16'h0123);

    // load held high: one conversion every 10 cycles
    n = 0; last_t = -1;
    data = 8'd42; load = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 39) load = 1'b0;
      if (done_a) begin
        n++;
        if (last_t < 0) check("b2b_first", t, 9);
        else            check("b2b_gap", t - last_t, 10);
        last_t = t;
      end
    end
    check("b2b_done_count", n, 4);
    check("b2b_bcd", bcd_a, 16'h0042);
    model_bcd = 16'h0042;

    // Reset four cycles into a conversion
    n = 0;
    data = 8'd199; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy_a}, 0);
    check("abort_bcd_in_rst", bcd_a, 16'h0000);
    check("abort_an", an_a, 4'b1110);
    check("abort_seg", seg_a, 7'b1000000);
    @(negedge clk);
    rst = 1'b0;
    model_bcd = 16'h0000;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (done_a) n++;
      if (t == 0) begin
        check("abort_an_rel", an_a, 4'b1110);
        check("abort_seg_rel", seg_a, 7'b1000000);
      end
    end
    check("abort_done_count", n, 0);
    check("abort_bcd", bcd_a, 16'h0000);

    // Scan sequences with stable committed values
    convert(8'd7, 16'h0007);
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      check_disp(model_bcd);
    end
    convert(8'd208, 16'h0208);
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      check_disp(model_bcd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot (2 kHz slot rate at 100 MHz).
REQ-003 Parameter BLANK_LZ, default 1: 1 blanks leading zero digits.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 data  input  8  unsigned binary value to display.
REQ-007 load  input  1  request to convert data; sampled only when busy=0.
REQ-008 busy  output  1  conversion in progress; load is ignored while high.
REQ-009 done  output  1  one-cycle pulse when new digits are committed.
REQ-010 bcd  output  16  committed digits {thous, huns, tens, ones}, 4 bits each.
REQ-011 an  output  4  digit anodes, active-low; an[0]=ones ... an[3]=thousands.
REQ-012 seg  output  7  segment cathodes, active-low; seg[0]=a ... seg[6]=g.

Function
REQ-013 The FSM SHALL have three states, IDLE, CONV and COMMIT, with these transitions:
- IDLE -> CONV on load=1: data is captured into the shift register, BCD scratch is cleared, iteration count=0.
- CONV stays for exactly 8 cycles, then -> COMMIT.
- COMMIT lasts 1 cycle, then -> IDLE.
REQ-014 Each CONV cycle SHALL first add 3 to every scratch nibble >=5, then shift {scratch, shift register} left by one bit (double-dabble).
REQ-015 busy SHALL be 1 in CONV and COMMIT and 0 in IDLE.
REQ-016 In COMMIT, bcd SHALL load the scratch value and done SHALL be 1; bcd SHALL be unchanged at all other times.
REQ-017 Latency: for a load sampled at edge N, done=1 and the new bcd value SHALL be visible in the cycle after edge N+9.
REQ-018 A load in IDLE on the COMMIT->IDLE edge SHALL be accepted on the next edge; back-to-back throughput SHALL be 10 cycles per conversion.
REQ-019 Any load while busy=1 SHALL be dropped without being queued, and data changes during CONV SHALL NOT affect the result.
REQ-020 The thousands digit SHALL always be 0 for 8-bit input, and the scratch register SHALL be 12 bits wide, zero-extended to 16 bits on bcd.
REQ-021 The scan prescaler SHALL count 0..SCAN_DIV-1 and wrap.
REQ-022 At the prescaler terminal count, the digit index SHALL advance 0->1->2->3->0.
REQ-023 Scanning SHALL run continuously and be independent of the FSM state.
REQ-024 For the active index i, an SHALL be low only at bit i, and seg SHALL be the encoding of bcd digit i.
REQ-025 The encoding SHALL be active-low, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
REQ-026 With BLANK_LZ=1, a digit SHALL be blank if it is zero and all more-significant digits are zero; the ones digit SHALL never be blanked.
REQ-027 During a blanked digit's slot, an SHALL be 4'b1111 and seg SHALL be 7'b1111111.
REQ-028 A commit SHALL take effect on the display from the next clock edge, with no change to the scan phase.

Reset
REQ-029 On rst=1, asynchronously:
- FSM=IDLE, busy=0, done=0, bcd=16'h0000.
- Prescaler=0, digit index=0.
- an=4'b1110, seg=7'b1000000.
REQ-030 Reset asserted during CONV SHALL abort the conversion with no done pulse, and bcd SHALL read 0 after release.
REQ-031 The first load SHALL be accepted on the first rising edge after rst is released.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef, the digit-count constant (4), the segment-pattern constants for 0-9 and blank, and the default SCAN_DIV.
REQ-033 A single combinational sub-module seg7_encode SHALL map a 4-bit digit plus a blank flag to the 7-bit seg pattern.
REQ-034 All registers SHALL be in the top level on clk with asynchronous rst.

Verification
REQ-035 load with data=8'd255 -> busy for 9 cycles; done pulses 9 cycles after load; bcd=16'h0255.
REQ-036 data=8'd0, then data=8'd100 -> bcd=16'h0000, then bcd=16'h0100, each with exactly one done pulse.
REQ-037 load held high continuously with data=8'd42 -> one done pulse every 10 cycles; loads during busy are dropped; bcd=16'h0042.
REQ-038 rst pulsed 4 cycles into a conversion of 8'd199 -> no done pulse; bcd=0; an=4'b1110 and seg=7'b1000000 after release.
REQ-039 SCAN_DIV=4, BLANK_LZ=1, bcd=16'h0007:
- an sequence 1110, 1111, 1111, 1111, with each pattern held 4 cycles.
- seg=7'b1111000 while an=1110.
REQ-040 SCAN_DIV=4, BLANK_LZ=0, bcd=16'h0208 -> an cycles 1110, 1101, 1011, 0111 with seg showing 8, 0, 2, 0.
